// File: rtl/fwrisc_wb_arb.sv
// N-to-1 Wishbone arbiter with fixed-priority or round-robin selection.
// A tenure is granted for the whole cyc assertion; a stalled target is aborted by a watchdog.
module fwrisc_wb_arb #(
  parameter int N_INITIATORS   = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int RR_MODE        = 0,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [N_INITIATORS*ADDR_WIDTH-1:0]    wbt_adr,
  input  logic [N_INITIATORS*DATA_WIDTH-1:0]    wbt_dat_w,
  output logic [N_INITIATORS*DATA_WIDTH-1:0]    wbt_dat_r,
  input  logic [N_INITIATORS*DATA_WIDTH/8-1:0]  wbt_sel,
  input  logic [N_INITIATORS-1:0]               wbt_cyc,
  input  logic [N_INITIATORS-1:0]               wbt_stb,
  input  logic [N_INITIATORS-1:0]               wbt_we,
  output logic [N_INITIATORS-1:0]               wbt_ack,
  output logic [N_INITIATORS-1:0]               wbt_err,
  output logic [ADDR_WIDTH-1:0]                 wbi_adr,
  output logic [DATA_WIDTH-1:0]                 wbi_dat_w,
  output logic [DATA_WIDTH/8-1:0]               wbi_sel,
  output logic                                  wbi_cyc,
  output logic                                  wbi_stb,
  output logic                                  wbi_we,
  input  logic [DATA_WIDTH-1:0]                 wbi_dat_r,
  input  logic                                  wbi_ack,
  input  logic                                  wbi_err,
  output logic [N_INITIATORS-1:0]               gnt,
  output logic                                  timeout
);

  localparam int N     = N_INITIATORS;
  localparam int SEL_W = DATA_WIDTH / 8;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int WD_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_TERM = 2'd2;

  logic [1:0]       state_reg, state_next;
  logic [IDX_W-1:0] gnt_idx_reg, gnt_idx_next;
  logic [IDX_W-1:0] last_idx_reg, last_idx_next;
  logic [WD_W-1:0]  wd_cnt_reg, wd_cnt_next;

  logic [ADDR_WIDTH-1:0] adr_arr   [N];
  logic [DATA_WIDTH-1:0] dat_w_arr [N];
  logic [SEL_W-1:0]      sel_arr   [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_slice
      assign adr_arr[gi]   = wbt_adr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign dat_w_arr[gi] = wbt_dat_w[gi*DATA_WIDTH +: DATA_WIDTH];
      assign sel_arr[gi]   = wbt_sel[gi*SEL_W +: SEL_W];
      assign wbt_dat_r[gi*DATA_WIDTH +: DATA_WIDTH] = wbi_dat_r;
    end
  endgenerate

  logic busy;
  logic term;
  logic cyc_g;
  logic stall;

  assign busy  = (state_reg == ST_BUSY);
  assign term  = (state_reg == ST_TERM);
  assign cyc_g = wbt_cyc[gnt_idx_reg];
  assign stall = wbt_stb[gnt_idx_reg] & ~wbi_ack & ~wbi_err;

  // Winner search; in round-robin mode it starts just after the previous winner.
  logic [IDX_W-1:0] win_idx;
  logic             win_found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      if (RR_MODE != 0) begin
        cand = IDX_W'((int'(last_idx_reg) + 1 + i) % N);
      end else begin
        cand = IDX_W'(i);
      end
      if (!win_found && wbt_cyc[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    gnt_idx_next  = gnt_idx_reg;
    last_idx_next = last_idx_reg;
    wd_cnt_next   = wd_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        wd_cnt_next = '0;
        if (win_found) begin
          state_next    = ST_BUSY;
          gnt_idx_next  = win_idx;
          last_idx_next = win_idx;
        end
      end
      ST_BUSY: begin
        if (!cyc_g) begin
          state_next  = ST_IDLE;
          wd_cnt_next = '0;
        end else if ((TIMEOUT_CYCLES > 0) && stall) begin
          // An ack in the limit cycle removes the stall, so the ack wins.
          if (wd_cnt_reg == WD_LAST) begin
            state_next  = ST_TERM;
            wd_cnt_next = '0;
          end else begin
            wd_cnt_next = wd_cnt_reg + 1'b1;
          end
        end else begin
          wd_cnt_next = '0;
        end
      end
      ST_TERM: begin
        state_next  = ST_IDLE;
        wd_cnt_next = '0;
      end
      default: begin
        state_next  = ST_IDLE;
        wd_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      gnt_idx_reg  <= '0;
      last_idx_reg <= IDX_LAST;
      wd_cnt_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      gnt_idx_reg  <= gnt_idx_next;
      last_idx_reg <= last_idx_next;
      wd_cnt_reg   <= wd_cnt_next;
    end
  end

  // Shared port carries the granted slice only while BUSY; TERM and IDLE drive zeros.
  always_comb begin
    wbi_adr   = '0;
    wbi_dat_w = '0;
    wbi_sel   = '0;
    wbi_cyc   = 1'b0;
    wbi_stb   = 1'b0;
    wbi_we    = 1'b0;
    if (busy) begin
      wbi_adr   = adr_arr[gnt_idx_reg];
      wbi_dat_w = dat_w_arr[gnt_idx_reg];
      wbi_sel   = sel_arr[gnt_idx_reg];
      wbi_cyc   = wbt_cyc[gnt_idx_reg];
      wbi_stb   = wbt_stb[gnt_idx_reg];
      wbi_we    = wbt_we[gnt_idx_reg];
    end
  end

  always_comb begin
    gnt     = '0;
    wbt_ack = '0;
    wbt_err = '0;
    if (busy) begin
      gnt[gnt_idx_reg]     = 1'b1;
      wbt_ack[gnt_idx_reg] = wbi_ack;
      wbt_err[gnt_idx_reg] = wbi_err;
    end else if (term) begin
      gnt[gnt_idx_reg]     = 1'b1;
      wbt_err[gnt_idx_reg] = 1'b1;
    end
  end

  assign timeout = term;

endmodule
